ras_stack: RTL and testbench
============================

Name: ras_stack

Overview:
- Parametrised return-address stack (RAS) for the pipelined processor's BAL/BR path.
- Replaces the fixed 8-entry, unchecked call stack with configurable depth, width and full-policy.
- Adds occupancy, overflow/underflow detection and a same-cycle push+pop (tail-call replace).
- The branch logic pushes PC+1 on BAL, pops on BR, and takes the BR target from top_addr.

Parameters:
- ADDR_W, 16: width of stored return addresses.
- DEPTH, 8: number of entries. Must be a power of two and at least 2.
- MODE, 0: full policy. 0 = saturate: a push when full is dropped. 1 = circular: a push when full overwrites the oldest entry.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  push push_addr this cycle.
- pop  input  1  pop the top entry this cycle.
- push_addr  input  ADDR_W  return address to store.
- err_clr  input  1  synchronous clear of the sticky error flags.
- top_addr  output  ADDR_W  current top entry. Reads 0 when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push occurred while full without a pop.
- underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Storage and state:
  - Storage is a DEPTH-entry array, circular.
  - wp is a $clog2(DEPTH)-bit write pointer; it wraps naturally modulo DEPTH.
  - The top entry is mem[wp-1].
- Reset (asynchronous, active-high):
  - wp=0, count=0, overflow=0, underflow=0.
  - Array contents are not reset.
  - Outputs after reset: top_addr=0, empty=1, full=0, count=0.
  - Reset asserted mid-operation discards all entries immediately.
- Outputs:
  - top_addr, empty, full and count are combinational from registered state, with zero latency.
  - A pushed value appears on top_addr in the cycle after the push edge.
- Per-cycle actions, evaluated at the rising clock edge:
  - Idle (push=0, pop=0): no change.
  - Push only, not full: mem[wp]<=push_addr, wp<=wp+1, count<=count+1.
  - Push only, full, MODE=0: no state change except overflow<=1.
  - Push only, full, MODE=1: mem[wp]<=push_addr, wp<=wp+1, count stays DEPTH, overflow<=1. The oldest entry is lost.
  - Pop only, not empty: wp<=wp-1, count<=count-1. The popped entry is not cleared.
  - Pop only, empty: no state change except underflow<=1.
  - Push+pop, not empty: replace the top, i.e. mem[wp-1]<=push_addr. wp and count are unchanged. No overflow, even when full.
  - Push+pop, empty: underflow<=1, then the push is performed normally, so count becomes 1.
- Sticky flags:
  - err_clr clears overflow and underflow at the edge.
  - If a new error event occurs in the same cycle as err_clr, the flag is set (set wins).
- Width rules:
  - count never exceeds DEPTH and never goes below 0.
  - Pointer arithmetic is modulo DEPTH; there is no separate wrap flag.
- Integration: the processor gates push/pop with its flush. The RAS has no speculation or rollback; a squashed BAL/BR must not assert push/pop.

Test Plan (DEPTH=4, ADDR_W=12 unless stated):
1. Reset, then push 0x101, 0x202, 0x303 -> count=3, top_addr=0x303. Then pop, pop -> top_addr=0x101, count=1, no flags.
2. MODE=0: push 0x1,0x2,0x3,0x4 -> full=1. Push 0x5 -> overflow=1, count=4, top_addr=0x4. Then 4 pops yield 0x4,0x3,0x2,0x1, then empty=1.
3. MODE=1: push 0x1..0x6 -> overflow=1, count=4. Pops yield 0x6,0x5,0x4,0x3, then empty=1 and top_addr=0.
4. Pop when empty -> underflow=1, count=0. Assert err_clr together with another empty pop -> underflow stays 1. err_clr alone -> underflow=0.
5. Push 0xA, 0xB, then push 0xC with pop in the same cycle -> count=2, top_addr=0xC. Pop -> top_addr=0xA. On an empty stack, push 0x7 with pop -> underflow=1, count=1, top_addr=0x7.
6. Push 3 entries, assert reset asynchronously between clock edges -> empty=1, count=0, top_addr=0 before the next edge. A following push of 0x55 gives top_addr=0x55.

Source files
------------

// File: rtl/ras_stack.sv
// Return-address stack: circular DEPTH-entry store of call return PCs.
// Ports: clock/reset, push/pop/push_addr, err_clr in; top_addr, count,
//   empty, full, sticky overflow/underflow out.
module ras_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8,
  parameter int MODE   = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          top_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_MAX = CW'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic              mem_we;
  logic [PW-1:0]     mem_wa;
  logic [PW-1:0]     top_idx;

  assign top_idx   = wp_q - P_ONE;
  assign empty     = (count_q == '0);
  assign full      = (count_q == C_MAX);
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign top_addr  = empty ? '0 : mem_q[top_idx];

  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    // Clear first so a same-cycle error event below wins.
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    mem_we  = 1'b0;
    mem_wa  = wp_q;
    unique case (1'b1)
      (push && pop): begin
        if (empty) begin
          // Pop has nothing to take; the push still lands.
          unf_d   = 1'b1;
          mem_we  = 1'b1;
          wp_d    = wp_q + P_ONE;
          count_d = count_q + C_ONE;
        end else begin
          // Tail call: overwrite top in place.
          mem_we = 1'b1;
          mem_wa = top_idx;
        end
      end
      (push && !pop): begin
        if (!full) begin
          mem_we  = 1'b1;
          wp_d    = wp_q + P_ONE;
          count_d = count_q + C_ONE;
        end else begin
          ovf_d = 1'b1;
          if (MODE == 1) begin
            // Writing at wp clobbers the oldest slot.
            mem_we = 1'b1;
            wp_d   = wp_q + P_ONE;
          end
        end
      end
      (!push && pop): begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          wp_d    = wp_q - P_ONE;
          count_d = count_q - C_ONE;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_wa] <= push_addr;
    end
  end

endmodule

// File: tb/tb_ras_stack.sv
// Bench for ras_stack: saturating and circular instances side by side,
// directed scenarios plus random traffic against a queue model.
module tb_ras_stack;

  localparam int AW = 12;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic          err_clr = 1'b0;

  logic [AW-1:0] s_top, c_top;
  logic [2:0]    s_cnt, c_cnt;
  logic          s_emp, c_emp, s_ful, c_ful;
  logic          s_ovf, c_ovf, s_unf, c_unf;

  logic [18:0] obs [2];

  int n_tot = 0;
  int n_pass = 0;

  logic [AW-1:0] mq [2][$];
  logic          mov [2];
  logic          mun [2];

  always #5 clock = ~clock;

  ras_stack #(.ADDR_W(AW), .DEPTH(D), .MODE(0)) u_sat (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .push_addr(push_addr), .err_clr(err_clr),
    .top_addr(s_top), .count(s_cnt), .empty(s_emp), .full(s_ful),
    .overflow(s_ovf), .underflow(s_unf)
  );

  ras_stack #(.ADDR_W(AW), .DEPTH(D), .MODE(1)) u_circ (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .push_addr(push_addr), .err_clr(err_clr),
    .top_addr(c_top), .count(c_cnt), .empty(c_emp), .full(c_ful),
    .overflow(c_ovf), .underflow(c_unf)
  );

  assign obs[0] = {s_top, s_cnt, s_emp, s_ful, s_ovf, s_unf};
  assign obs[1] = {c_top, c_cnt, c_emp, c_ful, c_ovf, c_unf};

  function automatic logic [18:0] pk(input logic [AW-1:0] t,
                                     input logic [2:0] c,
                                     input logic e, input logic f,
                                     input logic o, input logic u);
    return {t, c, e, f, o, u};
  endfunction

  function automatic logic [18:0] exp_vec(input int m);
    int sz;
    logic [AW-1:0] t;
    sz = mq[m].size();
    t = (sz > 0) ? mq[m][sz-1] : '0;
    return pk(t, 3'(sz), sz == 0, sz == D, mov[m], mun[m]);
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mov[m] = 1'b0;
      mun[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input logic p, input logic o,
                            input logic [AW-1:0] a, input logic c);
    logic eo, eu;
    eo = 1'b0;
    eu = 1'b0;
    if (p && o) begin
      if (mq[m].size() == 0) begin
        eu = 1'b1;
        mq[m].push_back(a);
      end else begin
        mq[m][mq[m].size()-1] = a;
      end
    end else if (p) begin
      if (mq[m].size() < D) begin
        mq[m].push_back(a);
      end else begin
        eo = 1'b1;
        if (m == 1) begin
          void'(mq[m].pop_front());
          mq[m].push_back(a);
        end
      end
    end else if (o) begin
      if (mq[m].size() == 0) eu = 1'b1;
      else void'(mq[m].pop_back());
    end
    mov[m] = eo | (mov[m] & ~c);
    mun[m] = eu | (mun[m] & ~c);
  endtask

  task automatic step(input logic p, input logic o,
                      input logic [AW-1:0] a, input logic c);
    push = p;
    pop = o;
    push_addr = a;
    err_clr = c;
    @(posedge clock);
    for (int m = 0; m < 2; m++) model_step(m, p, o, a, c);
    #1;
    push = 1'b0;
    pop = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(posedge clock);
    #1;
    for (int m = 0; m < 2; m++) begin
      n_tot++;
      if (obs[m] !== pk(0, 0, 1, 0, 0, 0))
        $display("FAIL reset_m%0d got %h want %h", m, obs[m],
                 pk(0, 0, 1, 0, 0, 0));
      else n_pass++;
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 0, 12'h101, 0);
    step(1, 0, 12'h202, 0);
    step(1, 0, 12'h303, 0);
    for (int m = 0; m < 2; m++) begin
      n_tot++;
      if (obs[m] !== pk(12'h303, 3, 0, 0, 0, 0))
        $display("FAIL basic_push_m%0d got %h want %h", m, obs[m],
                 pk(12'h303, 3, 0, 0, 0, 0));
      else n_pass++;
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int m = 0; m < 2; m++) begin
      n_tot++;
      if (obs[m] !== pk(12'h101, 1, 0, 0, 0, 0))
        $display("FAIL basic_pop_m%0d got %h want %h", m, obs[m],
                 pk(12'h101, 1, 0, 0, 0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 0, 12'(i), 0);
    n_tot++;
    if (obs[0] !== pk(12'h4, 4, 0, 1, 0, 0))
      $display("FAIL sat_full got %h want %h", obs[0],
               pk(12'h4, 4, 0, 1, 0, 0));
    else n_pass++;
    step(1, 0, 12'h5, 0);
    n_tot++;
    if (obs[0] !== pk(12'h4, 4, 0, 1, 1, 0))
      $display("FAIL sat_ovf got %h want %h", obs[0],
               pk(12'h4, 4, 0, 1, 1, 0));
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_tot++;
      if (s_top !== 12'(4 - i))
        $display("FAIL sat_pop%0d got %h want %h", i, s_top, 12'(4 - i));
      else n_pass++;
      step(0, 1, 0, 0);
    end
    n_tot++;
    if (obs[0] !== pk(0, 0, 1, 0, 1, 0))
      $display("FAIL sat_empty got %h want %h", obs[0],
               pk(0, 0, 1, 0, 1, 0));
    else n_pass++;
  endtask

  task automatic test_circular();
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, 0, 12'(i), 0);
    n_tot++;
    if (obs[1] !== pk(12'h6, 4, 0, 1, 1, 0))
      $display("FAIL circ_ovf got %h want %h", obs[1],
               pk(12'h6, 4, 0, 1, 1, 0));
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_tot++;
      if (c_top !== 12'(6 - i))
        $display("FAIL circ_pop%0d got %h want %h", i, c_top, 12'(6 - i));
      else n_pass++;
      step(0, 1, 0, 0);
    end
    n_tot++;
    if (obs[1] !== pk(0, 0, 1, 0, 1, 0))
      $display("FAIL circ_empty got %h want %h", obs[1],
               pk(0, 0, 1, 0, 1, 0));
    else n_pass++;
  endtask

  task automatic test_underflow();
    do_reset();
    step(0, 1, 0, 0);
    n_tot++;
    if (obs[0] !== pk(0, 0, 1, 0, 0, 1))
      $display("FAIL unf_set got %h want %h", obs[0],
               pk(0, 0, 1, 0, 0, 1));
    else n_pass++;
    step(0, 1, 0, 1);
    n_tot++;
    if (obs[1] !== pk(0, 0, 1, 0, 0, 1))
      $display("FAIL unf_setwins got %h want %h", obs[1],
               pk(0, 0, 1, 0, 0, 1));
    else n_pass++;
    step(0, 0, 0, 1);
    for (int m = 0; m < 2; m++) begin
      n_tot++;
      if (obs[m] !== pk(0, 0, 1, 0, 0, 0))
        $display("FAIL unf_clr_m%0d got %h want %h", m, obs[m],
                 pk(0, 0, 1, 0, 0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_replace();
    do_reset();
    step(1, 0, 12'hA, 0);
    step(1, 0, 12'hB, 0);
    step(1, 1, 12'hC, 0);
    n_tot++;
    if (obs[0] !== pk(12'hC, 2, 0, 0, 0, 0))
      $display("FAIL repl_top got %h want %h", obs[0],
               pk(12'hC, 2, 0, 0, 0, 0));
    else n_pass++;
    step(0, 1, 0, 0);
    n_tot++;
    if (obs[0] !== pk(12'hA, 1, 0, 0, 0, 0))
      $display("FAIL repl_pop got %h want %h", obs[0],
               pk(12'hA, 1, 0, 0, 0, 0));
    else n_pass++;
    do_reset();
    step(1, 1, 12'h7, 0);
    for (int m = 0; m < 2; m++) begin
      n_tot++;
      if (obs[m] !== pk(12'h7, 1, 0, 0, 0, 1))
        $display("FAIL repl_empty_m%0d got %h want %h", m, obs[m],
                 pk(12'h7, 1, 0, 0, 0, 1));
      else n_pass++;
    end
    // Full stack: push+pop replaces top without overflow.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 0, 12'(i), 0);
    step(1, 1, 12'h9, 0);
    for (int m = 0; m < 2; m++) begin
      n_tot++;
      if (obs[m] !== pk(12'h9, 4, 0, 1, 0, 0))
        $display("FAIL repl_full_m%0d got %h want %h", m, obs[m],
                 pk(12'h9, 4, 0, 1, 0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 12'(i + 8), 0);
    #2 reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_tot++;
      if (obs[m] !== pk(0, 0, 1, 0, 0, 0))
        $display("FAIL arst_m%0d got %h want %h", m, obs[m],
                 pk(0, 0, 1, 0, 0, 0));
      else n_pass++;
    end
    reset = 1'b0;
    model_clear();
    step(1, 0, 12'h55, 0);
    for (int m = 0; m < 2; m++) begin
      n_tot++;
      if (obs[m] !== pk(12'h55, 1, 0, 0, 0, 0))
        $display("FAIL arst_push_m%0d got %h want %h", m, obs[m],
                 pk(12'h55, 1, 0, 0, 0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic p, o, c;
    logic [AW-1:0] a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 99) < 6);
      a = AW'($urandom);
      step(p, o, a, c);
      for (int m = 0; m < 2; m++) begin
        n_tot++;
        if (obs[m] !== exp_vec(m))
          $display("FAIL rand_m%0d cyc %0d got %h want %h", m, i,
                   obs[m], exp_vec(m));
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_saturate();
    test_circular();
    test_underflow();
    test_replace();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
